ram: RTL and testbench
======================

Name: ram

Overview:
- Single-port synchronous static RAM, default 1024 words x 8 bits, used as general-purpose scratch storage.
- One chip-select and one write-enable; a registered read port with one-cycle latency.
- An asynchronous active-low reset clears the output register and invalidates all locations. A read of a never-written word after reset returns zero.

Parameters:
- ADDR_W, 10, address width in bits; DEPTH = 2**ADDR_W words.
- DATA_W, 8, word width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge except reset.
- rst_n  input  1  asynchronous, active-low reset.
- data_out  output  DATA_W  registered read data.
- data_in  input  DATA_W  write data.
- address  input  ADDR_W  word address, 0..DEPTH-1.
- write  input  1  1 = write cycle, 0 = read cycle; only meaningful when select=1.
- select  input  1  chip select, active high; 0 = idle.

Interface: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Storage:
  - mem[DEPTH] of DATA_W bits, not reset.
  - valid[DEPTH] one bit per word.
  - data_out register of DATA_W bits.
- Reset (rst_n=0, asynchronous, takes effect immediately regardless of clk):
  - data_out <= 0; all valid bits <= 0.
  - mem contents are don't-care; they are masked by valid.
  - Holds for as long as rst_n=0.
  - Release is synchronous to the next rising clk; the first operation is sampled on the first rising edge with rst_n=1.
- Each rising clk with rst_n=1, decode {select, write}:
  - select=0: idle. No write; data_out holds its previous value.
  - select=1, write=1: mem[address] <= data_in; valid[address] <= 1; data_out holds (no write-through).
  - select=1, write=0: data_out <= valid[address] ? mem[address] : 0.
- Latency:
  - Read data appears on data_out one cycle after the read is sampled, and stays until the next read or reset.
  - A write is visible to a read sampled on the next edge or later.
- Back-to-back: a write then a read of the same address on consecutive edges returns the new data.
- Address: the full ADDR_W bits are used, with no aliasing. Every value 0..DEPTH-1 is legal; no out-of-range case exists.
- Inputs are sampled only at rising clk; glitches between edges have no effect.
- X on write or select while select=1: implementation-defined, but no corruption of other addresses is allowed.
- Reset mid-operation: an edge coincident with rst_n=0 performs no write. After reset, all words read 0 until rewritten.
- Synthesizable. Nothing may depend on initial blocks for function.

Test Plan:
- Reset then read: assert rst_n=0 for 3 cycles, release, read addresses 0, 5, 1023 -> data_out=0 each, one cycle after each read.
- Full fill: for k=0..1023 write data_in=(2k)%256 at address k; then read k=0..1023 -> data_out=(2k)%256 (e.g. addr 3->6, 128->0, 1023->254).
- Random readback: after the fill, 20 reads at pseudo-random addresses (seed 35, addr = $random%1024 taken non-negative) -> each equals (2*addr)%256.
- Write/idle hold:
  - Read addr 10 gives 20.
  - Then select=0 for 5 cycles with data_in and address toggling -> data_out stays 20 and mem is unchanged.
  - Then a write at addr 10 of 0xAA -> data_out still 20.
  - Next read -> 0xAA.
- Reset mid-operation:
  - Pulse rst_n low between edges while write=1, select=1, address=7, data_in=0x55 -> data_out drops to 0 immediately; the write is not performed.
  - Read addr 7 after release -> 0.
  - Previously written addr 8 also reads 0.
- Back-to-back: write 0x3C at addr 512, read addr 512 on the next edge -> data_out=0x3C one cycle later; read addr 511 -> its last written value.

Source files
------------

// File: rtl/ram.sv
// ram: single-port synchronous static RAM with a registered read port.
//
// Ports:
//   clk      - system clock; all state changes on its rising edge except reset
//   rst_n    - asynchronous active-low reset; clears data_out and every valid bit
//   data_out - registered read data, updated one cycle after a read is sampled
//   data_in  - write data
//   address  - word address, 0..DEPTH-1 (full width decoded, no aliasing)
//   write    - 1 = write cycle, 0 = read cycle (only meaningful with select=1)
//   select   - chip select, active high; 0 = idle
//
// The storage array has no reset. A per-word valid bit (which is reset) masks
// stale contents, so a word that has not been written since reset reads as zero.
module ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] address,
  input  logic              write,
  input  logic              select
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  logic wr_en, rd_en;

  // Explicit ==1'b1 compares keep an X on write/select from enabling anything.
  assign wr_en = (select == 1'b1) && (write == 1'b1);
  assign rd_en = (select == 1'b1) && (write == 1'b0);

  // Read mux: unwritten words return zero regardless of what mem holds.
  always_comb begin
    data_out_d = data_out_q;
    if (rd_en) data_out_d = valid_q[address] ? mem_q[address] : '0;
  end

  // Storage array is not reset. Gating on rst_n means an edge that arrives
  // while reset is held performs no write.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem_q[address] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      data_out_q <= '0;
    end else begin
      if (wr_en) valid_q[address] <= 1'b1;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_ram.sv
module tb_ram;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_out;
  logic [DW-1:0] data_in;
  logic [AW-1:0] address;
  logic          write;
  logic          select;

  int total = 0;
  int bad   = 0;

  ram #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .data_out(data_out), .data_in(data_in),
    .address(address), .write(write), .select(select)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain arrays of contents, written flags and the output.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_val [DEPTH];
  logic [DW-1:0] m_out;

  typedef struct {
    string         name;
    logic          sel;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
    m_out = '0;
  endtask

  // One clock: drive on the falling edge, update model at the rising edge,
  // sample the DUT 1ns after it.
  task automatic cycle(input logic s, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output logic [DW-1:0] act);
    @(negedge clk);
    select = s; write = w; address = a; data_in = d;
    @(posedge clk);
    if (s && w) begin
      m_mem[a] = d;
      m_val[a] = 1'b1;
    end else if (s) begin
      m_out = m_val[a] ? m_mem[a] : '0;
    end
    #1 act = data_out;
  endtask

  task automatic run_vecs();
    logic [DW-1:0] act;
    foreach (vecs[i]) begin
      cycle(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].din, act);
      chk(vecs[i].name, act, vecs[i].exp);
    end
    vecs.delete();
  endtask

  initial begin
    logic [DW-1:0] act;
    integer seed;
    integer ra;

    rst_n = 1'b1; select = 1'b0; write = 1'b0; address = '0; data_in = '0;
    m_out = '0;

    // Reset for 3 cycles
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1 chk("reset_async_out", data_out, 8'h00);
    repeat (3) @(posedge clk);
    #1 chk("reset_held_out", data_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Reads of never-written words
    vecs.push_back('{"rd0_after_reset",    1, 0, 10'd0,    8'hFF, 8'h00});
    vecs.push_back('{"rd5_after_reset",    1, 0, 10'd5,    8'hFF, 8'h00});
    vecs.push_back('{"rd1023_after_reset", 1, 0, 10'd1023, 8'hFF, 8'h00});
    run_vecs();

    // Full fill then full readback
    for (int k = 0; k < DEPTH; k++) begin
      cycle(1'b1, 1'b1, AW'(k), DW'((2 * k) % 256), act);
      chk("fill_out_hold", act, m_out);
    end
    for (int k = 0; k < DEPTH; k++) begin
      cycle(1'b1, 1'b0, AW'(k), 8'h00, act);
      chk($sformatf("fill_rd_%0d", k), act, DW'((2 * k) % 256));
    end

    // Random readback, seed 35
    seed = 35;
    for (int i = 0; i < 20; i++) begin
      ra = $random(seed) % 1024;
      if (ra < 0) ra = -ra;
      cycle(1'b1, 1'b0, AW'(ra), 8'h00, act);
      chk($sformatf("rand_rd_%0d", ra), act, DW'((2 * ra) % 256));
    end

    // Idle hold, no write-through, then read of new data
    vecs.push_back('{"hold_rd10",    1, 0, 10'd10, 8'h00, 8'd20});
    vecs.push_back('{"hold_idle0",   0, 1, 10'd11, 8'hA5, 8'd20});
    vecs.push_back('{"hold_idle1",   0, 0, 10'd12, 8'h5A, 8'd20});
    vecs.push_back('{"hold_idle2",   0, 1, 10'd13, 8'hFF, 8'd20});
    vecs.push_back('{"hold_idle3",   0, 0, 10'd14, 8'h00, 8'd20});
    vecs.push_back('{"hold_idle4",   0, 1, 10'd15, 8'h33, 8'd20});
    vecs.push_back('{"hold_wr10",    1, 1, 10'd10, 8'hAA, 8'd20});
    vecs.push_back('{"hold_rd10_new",1, 0, 10'd10, 8'h00, 8'hAA});
    vecs.push_back('{"idle_no_wr11", 1, 0, 10'd11, 8'h00, 8'd22});
    vecs.push_back('{"idle_no_wr13", 1, 0, 10'd13, 8'h00, 8'd26});
    vecs.push_back('{"idle_no_wr15", 1, 0, 10'd15, 8'h00, 8'd30});
    vecs.push_back('{"rd10_again",   1, 0, 10'd10, 8'h00, 8'hAA});
    run_vecs();

    // Reset mid-operation: write to 7 pending across a reset edge
    cycle(1'b1, 1'b1, 10'd8, 8'h77, act);
    chk("pre_rst_wr8", act, 8'hAA);
    @(negedge clk);
    select = 1'b1; write = 1'b1; address = 10'd7; data_in = 8'h55;
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk("midrst_async_out", data_out, 8'h00);
    @(posedge clk);
    #1 chk("midrst_edge_out", data_out, 8'h00);
    @(negedge clk);
    select = 1'b0; write = 1'b0;
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 10'd7, 8'h00, act);
    chk("midrst_rd7", act, 8'h00);
    cycle(1'b1, 1'b0, 10'd8, 8'h00, act);
    chk("midrst_rd8", act, 8'h00);
    cycle(1'b1, 1'b0, 10'd100, 8'h00, act);
    chk("midrst_rd100", act, 8'h00);

    // Back-to-back write/read
    vecs.push_back('{"b2b_wr511", 1, 1, 10'd511, 8'h99, 8'h00});
    vecs.push_back('{"b2b_wr512", 1, 1, 10'd512, 8'h3C, 8'h00});
    vecs.push_back('{"b2b_rd512", 1, 0, 10'd512, 8'h00, 8'h3C});
    vecs.push_back('{"b2b_rd511", 1, 0, 10'd511, 8'h00, 8'h99});
    vecs.push_back('{"b2b_rd513", 1, 0, 10'd513, 8'h00, 8'h00});
    run_vecs();

    // Random traffic over a small address window against the model
    for (int i = 0; i < 400; i++) begin
      logic s, w;
      logic [AW-1:0] a;
      s = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1);
      a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15))
                                      : AW'(DEPTH - 1 - $urandom_range(0, 15));
      cycle(s, w, a, DW'($urandom), act);
      chk("rand_traffic", act, m_out);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
